// File: rtl/ladybird_csr_unit.sv
// Machine-mode CSR file: combinational read of i_addr, RW/RS/RC write committed on the clock.
// Optional 64-bit mcycle/cycle counter is built only when LADYBIRD_CSR_COUNTERS_EN is defined.

module ladybird_csr_reg #(
    parameter logic [11:0] ADDR  = 12'h000,
    parameter logic [31:0] MASK  = 32'hFFFF_FFFF,
    parameter logic [31:0] FIXED = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr_en,
    input  logic [1:0]  op,
    input  logic [11:0] addr,
    input  logic [31:0] data,
    output logic        hit,
    output logic [31:0] rdata
);
    logic [31:0] q;
    logic [31:0] nxt;

    assign hit   = (addr == ADDR);
    assign rdata = q | FIXED;

    // Set/clear operate on the architecturally visible value, then the mask drops read-zero bits.
    always_comb begin
        case (op)
            2'b10:   nxt = rdata | data;
            2'b11:   nxt = rdata & ~data;
            default: nxt = data;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            q <= '0;
        else if (wr_en && hit)
            q <= nxt & MASK;
    end
endmodule

module ladybird_csr_unit #(
    parameter logic [31:0] HART_ID = 32'd0
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [2:0]  i_op,
    input  logic        i_valid,
    input  logic [11:0] i_addr,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);
    typedef struct packed {
        logic        valid;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] data;
    } csr_req_t;

    localparam int NUM_REGS = 8;

    // Order: mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip (index 0 rightmost).
    localparam logic [NUM_REGS-1:0][11:0] REG_ADDR = {
        12'h344, 12'h343, 12'h342, 12'h341, 12'h340, 12'h305, 12'h304, 12'h300
    };
    localparam logic [NUM_REGS-1:0][31:0] REG_MASK = {
        32'h0000_0888, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0888, 32'h0000_0088
    };
    localparam logic [NUM_REGS-1:0][31:0] REG_FIXED = {
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_1800
    };

    csr_req_t req;
    logic     wr_en;
    logic     unused_op_hi;

    assign req          = '{valid: i_valid, op: i_op[1:0], addr: i_addr, data: i_data};
    assign unused_op_hi = i_op[2];

    // Set/clear with a zero operand is a pure read and must not write.
    assign wr_en = req.valid && (req.op != 2'b00) && !(req.op[1] && (req.data == '0));

    logic [NUM_REGS-1:0]       reg_hit;
    logic [NUM_REGS-1:0][31:0] reg_rdata;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        ladybird_csr_reg #(
            .ADDR  (REG_ADDR[g]),
            .MASK  (REG_MASK[g]),
            .FIXED (REG_FIXED[g])
        ) u_reg (
            .clk   (clk),
            .nrst  (nrst),
            .wr_en (wr_en),
            .op    (req.op),
            .addr  (req.addr),
            .data  (req.data),
            .hit   (reg_hit[g]),
            .rdata (reg_rdata[g])
        );
    end

`ifdef LADYBIRD_CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [31:0] lo_nxt;
    logic [31:0] hi_nxt;
    logic        wr_lo;
    logic        wr_hi;

    assign wr_lo = wr_en && (req.addr == 12'hB00);
    assign wr_hi = wr_en && (req.addr == 12'hB80);

    always_comb begin
        case (req.op)
            2'b10: begin
                lo_nxt = mcycle[31:0]  | req.data;
                hi_nxt = mcycle[63:32] | req.data;
            end
            2'b11: begin
                lo_nxt = mcycle[31:0]  & ~req.data;
                hi_nxt = mcycle[63:32] & ~req.data;
            end
            default: begin
                lo_nxt = req.data;
                hi_nxt = req.data;
            end
        endcase
    end

    // A software write to either half replaces the tick for that cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            mcycle <= '0;
        else if (wr_lo)
            mcycle[31:0] <= lo_nxt;
        else if (wr_hi)
            mcycle[63:32] <= hi_nxt;
        else
            mcycle <= mcycle + 64'd1;
    end
`endif

    always_comb begin
        o_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_hit[i])
                o_data = reg_rdata[i];
        end
        case (req.addr)
            12'h301: o_data = 32'h4000_0100;
            12'hF14: o_data = HART_ID;
`ifdef LADYBIRD_CSR_COUNTERS_EN
            12'hB00, 12'hC00: o_data = mcycle[31:0];
            12'hB80, 12'hC80: o_data = mcycle[63:32];
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ladybird_csr_unit.sv
// Bench for ladybird_csr_unit: directed vector table, reset/counter sequences, random ops vs a model.
module tb_ladybird_csr_unit;
    logic        clk;
    logic        nrst;
    logic [2:0]  i_op;
    logic        i_valid;
    logic [11:0] i_addr;
    logic [31:0] i_data;
    logic [31:0] o_data;

    int checks = 0;
    int errors = 0;

    ladybird_csr_unit #(.HART_ID(32'd3)) dut (
        .clk(clk), .nrst(nrst), .i_op(i_op), .i_valid(i_valid),
        .i_addr(i_addr), .i_data(i_data), .o_data(o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw value per address, read-zero/fixed bits applied on read.
    logic [31:0] mem [0:4095];
    logic [63:0] cnt;

    function automatic bit counters_on();
`ifdef LADYBIRD_CSR_COUNTERS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mdl_read(input logic [11:0] a);
        case (a)
            12'h300: return (mem[a] & 32'h88) | 32'h1800;
            12'h301: return 32'h4000_0100;
            12'h304, 12'h344: return mem[a] & 32'h888;
            12'h305: return mem[a] & ~32'h2;
            12'h340, 12'h342, 12'h343: return mem[a];
            12'h341: return mem[a] & ~32'h3;
            12'hF14: return 32'd3;
            12'hB00, 12'hC00: return counters_on() ? cnt[31:0] : 32'h0;
            12'hB80, 12'hC80: return counters_on() ? cnt[63:32] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit mdl_writable(input logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
            12'h342, 12'h343, 12'h344: return 1'b1;
            12'hB00, 12'hB80: return counters_on();
            default: return 1'b0;
        endcase
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        cnt = 64'h0;
    endtask

    // One clock edge of the architecture.
    task automatic mdl_step(input logic [2:0] op, input logic v, input logic [11:0] a,
                            input logic [31:0] d);
        logic [31:0] old, nv;
        bit wr;
        old = mdl_read(a);
        wr  = v && (op[1:0] != 2'b00) && !(op[1] && d == 32'h0) && mdl_writable(a);
        case (op[1:0])
            2'b10:   nv = old | d;
            2'b11:   nv = old & ~d;
            default: nv = d;
        endcase
        if (wr && a == 12'hB00)      cnt[31:0]  = nv;
        else if (wr && a == 12'hB80) cnt[63:32] = nv;
        else                         cnt        = cnt + 64'd1;
        if (wr && a != 12'hB00 && a != 12'hB80) mem[a] = nv;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive at posedge+1, check pre-write o_data at posedge+3, then take the edge.
    task automatic apply(input logic [2:0] op, input logic v, input logic [11:0] a,
                         input logic [31:0] d, input string nm, input bit use_exp,
                         input logic [31:0] exp);
        i_op = op; i_valid = v; i_addr = a; i_data = d;
        #2;
        chk(nm, o_data, use_exp ? exp : mdl_read(a));
        @(posedge clk);
        mdl_step(op, v, a, d);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic        valid;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [$];
    logic [11:0] pool [0:19];

    initial begin
        vecs.push_back('{3'b000, 1'b0, 12'h300, 32'h0, 32'h0000_1800, "mstatus_rst"});
        vecs.push_back('{3'b000, 1'b0, 12'hF14, 32'h0, 32'h0000_0003, "mhartid"});
        vecs.push_back('{3'b000, 1'b0, 12'h301, 32'h0, 32'h4000_0100, "misa"});
        vecs.push_back('{3'b001, 1'b1, 12'h340, 32'hDEADBEEF, 32'h0, "rw_scratch_pre"});
        vecs.push_back('{3'b011, 1'b1, 12'h340, 32'h0000FFFF, 32'hDEADBEEF, "rw_scratch_post"});
        vecs.push_back('{3'b000, 1'b0, 12'h340, 32'h0, 32'hDEAD0000, "rc_scratch"});
        vecs.push_back('{3'b010, 1'b1, 12'h341, 32'h7, 32'h0, "rs_mepc_pre"});
        vecs.push_back('{3'b000, 1'b0, 12'h341, 32'h0, 32'h4, "rs_mepc"});
        vecs.push_back('{3'b110, 1'b1, 12'h340, 32'h0, 32'hDEAD0000, "rsi_zero_pre"});
        vecs.push_back('{3'b000, 1'b0, 12'h340, 32'h0, 32'hDEAD0000, "rsi_zero"});
        vecs.push_back('{3'b001, 1'b1, 12'h300, 32'hFFFFFFFF, 32'h1800, "rw_mstatus_pre"});
        vecs.push_back('{3'b000, 1'b0, 12'h300, 32'h0, 32'h1888, "rw_mstatus"});
        vecs.push_back('{3'b001, 1'b1, 12'hF11, 32'h1, 32'h0, "rw_mvendorid_pre"});
        vecs.push_back('{3'b000, 1'b0, 12'hF11, 32'h0, 32'h0, "ro_mvendorid"});
        vecs.push_back('{3'b000, 1'b0, 12'h7C0, 32'h0, 32'h0, "unimpl"});
        vecs.push_back('{3'b001, 1'b1, 12'h342, 32'h12345678, 32'h0, "rw_mcause_pre"});
        vecs.push_back('{3'b001, 1'b0, 12'h342, 32'hFFFFFFFF, 32'h12345678, "novalid_pre"});
        vecs.push_back('{3'b000, 1'b0, 12'h342, 32'h0, 32'h12345678, "novalid"});
        vecs.push_back('{3'b101, 1'b1, 12'h305, 32'h1F, 32'h0, "rwi_mtvec_pre"});
        vecs.push_back('{3'b000, 1'b0, 12'h305, 32'h0, 32'h1D, "rwi_mtvec"});
        vecs.push_back('{3'b001, 1'b1, 12'h304, 32'hFFFFFFFF, 32'h0, "rw_mie_pre"});
        vecs.push_back('{3'b111, 1'b1, 12'h304, 32'h8, 32'h888, "rw_mie"});
        vecs.push_back('{3'b000, 1'b0, 12'h304, 32'h0, 32'h880, "rci_mie"});
        vecs.push_back('{3'b010, 1'b1, 12'h344, 32'hFFFF, 32'h0, "rs_mip_pre"});
        vecs.push_back('{3'b100, 1'b1, 12'h344, 32'h0, 32'h888, "rs_mip"});
        vecs.push_back('{3'b000, 1'b0, 12'h344, 32'h0, 32'h888, "nop100_mip"});

        pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                 12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0,
                 12'hB00, 12'hB80, 12'hC00, 12'hC80, 12'h000, 12'hFFF};

        nrst = 1'b0; i_op = 3'b000; i_valid = 1'b0; i_addr = 12'h300; i_data = '0;
        mdl_reset();
        #2;
        chk("reset_mstatus", o_data, 32'h0000_1800);
        @(posedge clk); #1;
        nrst = 1'b1;

        foreach (vecs[i])
            apply(vecs[i].op, vecs[i].valid, vecs[i].addr, vecs[i].data, vecs[i].name, 1'b1, vecs[i].exp);

        // Async reset between edges with a write pending.
        i_op = 3'b001; i_valid = 1'b1; i_addr = 12'h342; i_data = 32'hAAAA5555;
        #2;
        nrst = 1'b0;
        #1;
        chk("async_rst_mcause", o_data, 32'h0);
        mdl_reset();
        @(posedge clk); #1;
        chk("rst_discard_write", o_data, 32'h0);
        i_addr = 12'h300; i_valid = 1'b0;
        #1;
        chk("rst_mstatus", o_data, 32'h0000_1800);
        nrst = 1'b1;

`ifdef LADYBIRD_CSR_COUNTERS_EN
        apply(3'b001, 1'b1, 12'hB00, 32'hFFFFFFFF, "cyc_lo_wr", 1'b0, 32'h0);
        apply(3'b001, 1'b1, 12'hB80, 32'h0, "cyc_hi_wr", 1'b0, 32'h0);
        apply(3'b000, 1'b0, 12'hB80, 32'h0, "cyc_hi_pre", 1'b1, 32'h0);
        apply(3'b000, 1'b0, 12'hB80, 32'h0, "cyc_hi_carry", 1'b1, 32'h1);
        apply(3'b000, 1'b0, 12'hC00, 32'h0, "cycle_alias", 1'b1, 32'h1);
        apply(3'b000, 1'b0, 12'hB00, 32'h0, "mcycle_lo", 1'b1, 32'h2);
        apply(3'b001, 1'b1, 12'hC80, 32'h5, "cycleh_ro", 1'b1, 32'h1);
        apply(3'b000, 1'b0, 12'hB80, 32'h0, "cycleh_ro_chk", 1'b1, 32'h1);
`else
        apply(3'b001, 1'b1, 12'hB00, 32'h1234, "no_cnt_wr", 1'b1, 32'h0);
        apply(3'b000, 1'b0, 12'hB00, 32'h0, "no_cnt_b00", 1'b1, 32'h0);
        apply(3'b000, 1'b0, 12'hC80, 32'h0, "no_cnt_c80", 1'b1, 32'h0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [2:0]  op;
            logic [31:0] d;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       d = 32'h0;
                1:       d = 32'($urandom_range(0, 31));
                default: d = $urandom;
            endcase
            apply(op, 1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 19)], d,
                  "random", 1'b0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ladybird_csr_unit.md
LADYBIRD_CSR_UNIT -- requirements
Module: ladybird_csr_unit

Interface
REQ-001 Parameter HART_ID, default 32'd0, value returned by mhartid.
REQ-002 Port clk  input  1  clock; all state updates on rising edge.
REQ-003 Port nrst  input  1  reset, asynchronous, active-low.
REQ-004 Port i_op  input  3  instruction funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 no operation.
REQ-005 Port i_valid  input  1  request strobe; a write is considered only when high.
REQ-006 Port i_addr  input  12  CSR address.
REQ-007 Port i_data  input  32  source operand; rs1 value, or 5-bit immediate zero-extended by the caller.
REQ-008 Port o_data  output  32  combinational read of the CSR at i_addr, pre-write value.

Function
REQ-009 o_data SHALL be purely combinational from i_addr and current state, independent of i_valid and i_op.
REQ-010 Write effect selected by i_op[1:0]: 01 new=i_data; 10 new=old|i_data; 11 new=old&~i_data; i_op[2] ignored.
REQ-011 Set/clear with i_data==0 SHALL NOT write; RW/RWI always write.
REQ-012 Write committed at the rising edge where i_valid=1 and i_op[1:0]!=00; new value visible on o_data the next cycle.
REQ-013 Implemented CSRs: mstatus 0x300, misa 0x301 (RO 0x40000100), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mvendorid 0xF11 (RO 0), marchid 0xF12 (RO 0), mimpid 0xF13 (RO 0), mhartid 0xF14 (RO HART_ID).
REQ-014 mstatus: only bits 3 (MIE) and 7 (MPIE) writable; bits 12:11 (MPP) read 2'b11; all other bits read 0.
REQ-015 mie/mip: only bits 3, 7, 11 writable; others read 0.
REQ-016 mtvec: bit 1 reads 0; all other bits writable.
REQ-017 mepc: bits 1:0 read 0.
REQ-018 mscratch, mcause, mtval: all 32 bits writable.
REQ-019 Unimplemented addresses read 0; writes to them or to read-only CSRs ignored without error.

Reset
REQ-020 nrst low SHALL immediately clear state independent of clk: mstatus=0x00001800, mie, mip, mtvec, mscratch, mepc, mcause, mtval all 0; mcycle=0 when present.
REQ-021 During reset o_data reflects reset values; reset asserted mid-operation discards the pending write.

Configuration
REQ-022 Macro LADYBIRD_CSR_COUNTERS_EN defined: 64-bit mcycle counter; mcycle 0xB00 (low), mcycleh 0xB80 (high) read/write; cycle 0xC00 and cycleh 0xC80 read-only aliases.
REQ-023 Counter increments by 1 every clock out of reset, wraps 2^64-1 -> 0; a write to mcycle/mcycleh in a cycle replaces that half and suppresses the increment that cycle.
REQ-024 Macro not defined: no counter logic; 0xB00, 0xB80, 0xC00, 0xC80 behave as unimplemented (read 0).

Verification
REQ-025 Reset, then read 0x300 -> 0x00001800; read 0xF14 with HART_ID=3 -> 0x00000003; read 0x301 -> 0x40000100.
REQ-026 RW 0x340 data 0xDEADBEEF -> o_data same cycle 0x00000000, next cycle 0xDEADBEEF; then RC 0x340 data 0x0000FFFF -> next read 0xDEAD0000.
REQ-027 RS 0x341 data 0x00000007 -> mepc reads 0x00000004; RSI with i_data 0 on 0x340 -> value unchanged.
REQ-028 RW 0x300 data 0xFFFFFFFF -> reads 0x00001888; RW 0xF11 data 0x1 -> still reads 0; read 0x7C0 -> 0.
REQ-029 i_valid=0 with i_op=001 on 0x342 -> no change; nrst pulsed low mid-cycle after writing 0x342 -> 0 immediately.
REQ-030 With LADYBIRD_CSR_COUNTERS_EN: RW 0xB00 0xFFFFFFFF, 0xB80 0 -> two cycles later 0xB80 reads 1, 0xC00 tracks 0xB00; without macro 0xB00 reads 0.
